j1_io_responder: RTL

- Responder on the CPU's I/O port; decodes io_rd/io_wr strobes with mem_addr.
- Writes take dout; read data returns on io_din.
- Contains an LED register, a 1-deep byte TX holding register with valid/ready output, an RX byte FIFO with sticky overflow, and a 16-bit free-running timer.
- Sits between the core and board-level byte serialisers.

---
 rtl/j1_io_responder.sv | 126 ++++++++++++
 1 files changed

// File: rtl/j1_io_responder.sv
// I/O-port responder for the J1 core: LED register, one-byte TX holding register,
// RX byte FIFO with sticky overflow and a free-running 16-bit timer.
module j1_io_responder #(
    parameter int WIDTH    = 16,
    parameter int RX_DEPTH = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             io_rd,
    input  logic             io_wr,
    input  logic [15:0]      mem_addr,
    input  logic [WIDTH-1:0] dout,
    output logic [WIDTH-1:0] io_din,
    output logic [7:0]       leds,
    output logic [7:0]       tx_data,
    output logic             tx_valid,
    input  logic             tx_ready,
    input  logic [7:0]       rx_data,
    input  logic             rx_valid
);
    localparam int          PW       = $clog2(RX_DEPTH);
    localparam logic [PW:0] FULL_CNT = (PW+1)'(RX_DEPTH);
    localparam logic [PW:0] CNT_ONE  = (PW+1)'(1);
    localparam logic [PW-1:0] PTR_ONE = PW'(1);

    localparam logic [15:0] A_LEDS   = 16'h0001;
    localparam logic [15:0] A_TX     = 16'h0002;
    localparam logic [15:0] A_RX     = 16'h0004;
    localparam logic [15:0] A_STATUS = 16'h0008;
    localparam logic [15:0] A_TIMER  = 16'h0010;

    logic wr_leds, wr_tx, wr_status, wr_timer, rd_rx;
    assign wr_leds   = io_wr && (mem_addr == A_LEDS);
    assign wr_tx     = io_wr && (mem_addr == A_TX);
    assign wr_status = io_wr && (mem_addr == A_STATUS);
    assign wr_timer  = io_wr && (mem_addr == A_TIMER);
    assign rd_rx     = io_rd && (mem_addr == A_RX);

    // TX handshake: a byte moves to the sink on every rising edge where
    // tx_valid && tx_ready; tx_data never changes while tx_valid is high
    // except by a reload on that same transfer edge.
    logic tx_xfer, tx_load;
    assign tx_xfer = tx_valid && tx_ready;
    assign tx_load = wr_tx && (!tx_valid || tx_xfer);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            tx_data  <= 8'h00;
            tx_valid <= 1'b0;
        end else if (tx_load) begin
            tx_data  <= dout[7:0];
            tx_valid <= 1'b1;
        end else if (tx_xfer) begin
            tx_valid <= 1'b0;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset)        leds <= 8'h00;
        else if (wr_leds) leds <= dout[7:0];
    end

    // RX FIFO: a push into a full FIFO is only legal when the head leaves in
    // the same cycle, so the slot being overwritten is the one being read out.
    logic [7:0]    rx_mem [RX_DEPTH];
    logic [PW-1:0] wr_ptr, rd_ptr;
    logic [PW:0]   rx_count;
    logic          rx_ovf, rx_avail, rx_full, pop, push, ovf_set;

    assign rx_avail = (rx_count != '0);
    assign rx_full  = (rx_count == FULL_CNT);
    assign pop      = rd_rx && rx_avail;
    assign push     = rx_valid && (!rx_full || pop);
    assign ovf_set  = rx_valid && rx_full && !pop;

    always_ff @(posedge clk) begin
        if (push) rx_mem[wr_ptr] <= rx_data;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            rx_count <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + PTR_ONE;
            if (pop)  rd_ptr <= rd_ptr + PTR_ONE;
            if (push && !pop)      rx_count <= rx_count + CNT_ONE;
            else if (pop && !push) rx_count <= rx_count - CNT_ONE;
        end
    end

    // A new overflow outranks a clearing STATUS write in the same cycle.
    always_ff @(posedge clk or posedge reset) begin
        if (reset)          rx_ovf <= 1'b0;
        else if (ovf_set)   rx_ovf <= 1'b1;
        else if (wr_status) rx_ovf <= 1'b0;
    end

    logic [15:0] timer;
    always_ff @(posedge clk or posedge reset) begin
        if (reset)         timer <= 16'h0000;
        else if (wr_timer) timer <= dout[15:0];
        else               timer <= timer + 16'h0001;
    end

    // Read data is built from pre-update state, so read-with-write returns old values.
    logic [WIDTH-1:0] rd_data;
    always_comb begin
        rd_data = '0;
        if (io_rd) begin
            case (mem_addr)
                A_LEDS:   rd_data[7:0]  = leds;
                A_RX:     rd_data[7:0]  = rx_avail ? rx_mem[rd_ptr] : 8'h00;
                A_STATUS: rd_data[2:0]  = {rx_ovf, !tx_valid, rx_avail};
                A_TIMER:  rd_data[15:0] = timer;
                default:  ;
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset)      io_din <= '0;
        else if (io_rd) io_din <= rd_data;
    end
endmodule
